// File: rtl/auto_codebreaker.sv
// auto_codebreaker: automatic guess generator for the hex code-breaking game.
// Scans the 16-bit candidate space upward and issues only candidates consistent with all stored feedback.
module auto_codebreaker #(
    parameter int HIST_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic [15:0] guess_o,
    output logic        guess_valid_o,
    input  logic        fb_valid_i,
    input  logic [3:0]  correct_place_count_i,
    input  logic [3:0]  wrong_place_count_i,
    output logic        busy_o,
    output logic        solved_o,
    output logic        failed_o,
    output logic [3:0]  guess_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    localparam logic [3:0] HIST_LAST = 4'(HIST_DEPTH - 1);

    // Greedy digit matching: each candidate digit claims the first unused equal guess digit.
    function automatic logic [7:0] score(input logic [15:0] c, input logic [15:0] g);
        logic [3:0] correct;
        logic [3:0] common;
        logic [3:0] used;
        logic       found;
        logic       hit;
        correct = 4'd0;
        common  = 4'd0;
        used    = 4'd0;
        for (int i = 0; i < 4; i++) begin
            correct = correct + {3'd0, (c[4*i +: 4] == g[4*i +: 4])};
        end
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
                hit     = !found && !used[j] && (c[4*i +: 4] == g[4*j +: 4]);
                used[j] = used[j] | hit;
                found   = found | hit;
            end
            common = common + {3'd0, found};
        end
        return {correct, common - correct};
    endfunction

    state_e      state_q, state_d;
    logic [15:0] cand_q, cand_d;
    logic [15:0] guess_q, guess_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic [3:0]  hist_cnt_q, hist_cnt_d;
    logic        guess_valid_q, busy_q, solved_q, failed_q;
    logic [15:0] hist_guess_q [HIST_DEPTH];
    logic [3:0]  hist_corr_q  [HIST_DEPTH];
    logic [3:0]  hist_wrong_q [HIST_DEPTH];
    logic        hist_we_s;
    logic        consistent_s;
    logic [4:0]  fb_sum_s;
    logic        fb_bad_s;

    assign fb_sum_s = {1'b0, correct_place_count_i} + {1'b0, wrong_place_count_i};
    assign fb_bad_s = (correct_place_count_i > 4'd4) || (wrong_place_count_i > 4'd4) || (fb_sum_s > 5'd4);

    // Check the current candidate against every valid history entry in parallel.
    always_comb begin
        consistent_s = 1'b1;
        for (int e = 0; e < HIST_DEPTH; e++) begin
            if ((4'(e) < hist_cnt_q) &&
                (score(cand_q, hist_guess_q[e]) != {hist_corr_q[e], hist_wrong_q[e]})) begin
                consistent_s = 1'b0;
            end else begin
                consistent_s = consistent_s;
            end
        end
    end

    // Next-state logic; start overrides everything, including coincident feedback.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        guess_d    = guess_q;
        gcnt_d     = gcnt_q;
        hist_cnt_d = hist_cnt_q;
        hist_we_s  = 1'b0;
        if (start_i) begin
            state_d    = ST_SEARCH;
            cand_d     = 16'h0000;
            gcnt_d     = 4'd0;
            hist_cnt_d = 4'd0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (consistent_s) begin
                        state_d = ST_ISSUE;
                        guess_d = cand_q;
                        gcnt_d  = (gcnt_q == 4'd15) ? gcnt_q : gcnt_q + 4'd1;
                    end else if (cand_q == 16'hFFFF) begin
                        state_d = ST_FAIL;
                    end else begin
                        cand_d = cand_q + 16'd1;
                    end
                end
                ST_ISSUE: begin
                    if (!fb_valid_i) begin
                        state_d = ST_ISSUE;
                    end else if (correct_place_count_i == 4'd4) begin
                        state_d = ST_DONE;
                    end else if (fb_bad_s || (guess_q == 16'hFFFF)) begin
                        state_d = ST_FAIL;
                    end else begin
                        hist_we_s  = 1'b1;
                        hist_cnt_d = hist_cnt_q + 4'd1;
                        if (hist_cnt_q == HIST_LAST) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_SEARCH;
                            cand_d  = guess_q + 16'd1;
                        end
                    end
                end
                ST_IDLE, ST_DONE, ST_FAIL: state_d = state_q;
                default:                   state_d = ST_FAIL;
            endcase
        end
    end

    // State, counters and status flags; flags are decoded from the next state so they are registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cand_q        <= 16'h0000;
            guess_q       <= 16'h0000;
            gcnt_q        <= 4'd0;
            hist_cnt_q    <= 4'd0;
            guess_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            solved_q      <= 1'b0;
            failed_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            guess_q       <= guess_d;
            gcnt_q        <= gcnt_d;
            hist_cnt_q    <= hist_cnt_d;
            guess_valid_q <= (state_d == ST_ISSUE);
            busy_q        <= (state_d == ST_SEARCH) || (state_d == ST_ISSUE);
            solved_q      <= (state_d == ST_DONE);
            failed_q      <= (state_d == ST_FAIL);
        end
    end

    // Feedback history; a slot is written only when its index equals the current count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < HIST_DEPTH; e++) begin
                hist_guess_q[e] <= 16'h0000;
                hist_corr_q[e]  <= 4'd0;
                hist_wrong_q[e] <= 4'd0;
            end
        end else begin
            for (int e = 0; e < HIST_DEPTH; e++) begin
                if (hist_we_s && (hist_cnt_q == 4'(e))) begin
                    hist_guess_q[e] <= guess_q;
                    hist_corr_q[e]  <= correct_place_count_i;
                    hist_wrong_q[e] <= wrong_place_count_i;
                end
            end
        end
    end

    assign guess_o       = guess_q;
    assign guess_valid_o = guess_valid_q;
    assign busy_o        = busy_q;
    assign solved_o      = solved_q;
    assign failed_o      = failed_q;
    assign guess_count_o = gcnt_q;

endmodule

// File: tb/tb_auto_codebreaker.sv
// Bench for auto_codebreaker: directed vector table, hand sequences and model-scored self-play.
// Instances: 0 default depth, 1 depth 1, 2 and 3 depth 15 for the two self-play secrets.
module tb_auto_codebreaker;

    logic clk;
    logic rst_n;
    logic [3:0]       start_s;
    logic [3:0]       fbv_s;
    logic [3:0][3:0]  cc_s;
    logic [3:0][3:0]  wc_s;
    logic [3:0][15:0] guess_s;
    logic [3:0]       gv_s;
    logic [3:0]       busy_s;
    logic [3:0]       solved_s;
    logic [3:0]       failed_s;
    logic [3:0][3:0]  gcnt_s;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar u = 0; u < 4; u++) begin : g_dut
        localparam int D = (u == 0) ? 8 : ((u == 1) ? 1 : 15);
        auto_codebreaker #(.HIST_DEPTH(D)) dut (
            .clk_i                 (clk),
            .rst_ni                (rst_n),
            .start_i               (start_s[u]),
            .guess_o               (guess_s[u]),
            .guess_valid_o         (gv_s[u]),
            .fb_valid_i            (fbv_s[u]),
            .correct_place_count_i (cc_s[u]),
            .wrong_place_count_i   (wc_s[u]),
            .busy_o                (busy_s[u]),
            .solved_o              (solved_s[u]),
            .failed_o              (failed_s[u]),
            .guess_count_o         (gcnt_s[u])
        );
    end

    typedef struct packed {
        logic        st;
        logic        fv;
        logic [3:0]  c;
        logic [3:0]  w;
        logic        gv;
        logic [15:0] g;
        logic        busy;
        logic        solved;
        logic        failed;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [7:0] model_score(input logic [15:0] a, input logic [15:0] b);
        int ca [16];
        int cb [16];
        int cor;
        int com;
        for (int v = 0; v < 16; v++) begin
            ca[v] = 0;
            cb[v] = 0;
        end
        cor = 0;
        com = 0;
        for (int i = 0; i < 4; i++) begin
            if (a[4*i +: 4] == b[4*i +: 4]) cor++;
            ca[a[4*i +: 4]]++;
            cb[b[4*i +: 4]]++;
        end
        for (int v = 0; v < 16; v++) com += (ca[v] < cb[v]) ? ca[v] : cb[v];
        return {4'(cor), 4'(com - cor)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int u, input logic st, input logic fv, input logic [3:0] c, input logic [3:0] w);
        start_s[u] = st;
        fbv_s[u]   = fv;
        cc_s[u]    = c;
        wc_s[u]    = w;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic play(input int u, input logic [15:0] secret, input string tag);
        logic [15:0] hg [$];
        logic [7:0]  hs [$];
        logic [15:0] g;
        logic [7:0]  sc;
        int          waited;
        int          issued;
        bit          done;
        drive(u, 1'b1, 1'b0, 4'd0, 4'd0);
        step();
        drive(u, 1'b0, 1'b0, 4'd0, 4'd0);
        done   = 1'b0;
        issued = 0;
        while (!done) begin
            waited = 0;
            while (!gv_s[u] && !failed_s[u] && waited < 70000) begin
                step();
                waited++;
            end
            if (!gv_s[u]) begin
                chk({tag, " guess_valid"}, 32'(gv_s[u]), 32'd1);
                done = 1'b1;
            end else begin
                g = guess_s[u];
                issued++;
                for (int e = 0; e < hg.size(); e++) begin
                    chk($sformatf("%s consistent g%0d e%0d", tag, issued, e), 32'(model_score(g, hg[e])), 32'(hs[e]));
                end
                sc = model_score(secret, g);
                hg.push_back(g);
                hs.push_back(sc);
                drive(u, 1'b0, 1'b1, sc[7:4], sc[3:0]);
                step();
                drive(u, 1'b0, 1'b0, 4'd0, 4'd0);
                if (sc[7:4] == 4'd4 || issued >= 20) done = 1'b1;
            end
        end
        chk({tag, " solved"}, 32'(solved_s[u]), 32'd1);
        chk({tag, " failed"}, 32'(failed_s[u]), 32'd0);
        chk({tag, " busy"},   32'(busy_s[u]),   32'd0);
        chk({tag, " guess"},  32'(guess_s[u]),  32'(secret));
        chk({tag, " count"},  32'(gcnt_s[u]),   32'(issued));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " guess"},  32'(guess_s[0]),  32'h0);
        chk({tag, " gv"},     32'(gv_s[0]),     32'd0);
        chk({tag, " busy"},   32'(busy_s[0]),   32'd0);
        chk({tag, " solved"}, 32'(solved_s[0]), 32'd0);
        chk({tag, " failed"}, 32'(failed_s[0]), 32'd0);
        chk({tag, " count"},  32'(gcnt_s[0]),   32'd0);
    endtask

    initial begin
        int  n;
        bit  seen;
        //           st    fv    c     w     gv    guess     busy  solv  fail  cnt
        tbl[0]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[2]  = '{1'b0, 1'b1, 4'd4, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[3]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[4]  = '{1'b0, 1'b1, 4'd4, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[5]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[7]  = '{1'b0, 1'b1, 4'd3, 4'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[8]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[9]  = '{1'b0, 1'b1, 4'd4, 4'd0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 4'd2};
        tbl[10] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[12] = '{1'b1, 1'b1, 4'd3, 4'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[13] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[14] = '{1'b0, 1'b1, 4'd2, 4'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1};
        tbl[15] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1};
        tbl[16] = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1};
        tbl[17] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0};
        tbl[18] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1};
        tbl[19] = '{1'b0, 1'b1, 4'd5, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd1};

        rst_n = 1'b0;
        for (int u = 0; u < 4; u++) drive(u, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        step();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        step();
        chk("idle gv",   32'(gv_s[0]),   32'd0);
        chk("idle busy", 32'(busy_s[0]), 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(0, tbl[i].st, tbl[i].fv, tbl[i].c, tbl[i].w);
            step();
            drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
            chk($sformatf("row%0d gv", i),     32'(gv_s[0]),     32'(tbl[i].gv));
            chk($sformatf("row%0d guess", i),  32'(guess_s[0]),  32'(tbl[i].g));
            chk($sformatf("row%0d busy", i),   32'(busy_s[0]),   32'(tbl[i].busy));
            chk($sformatf("row%0d solved", i), 32'(solved_s[0]), 32'(tbl[i].solved));
            chk($sformatf("row%0d failed", i), 32'(failed_s[0]), 32'(tbl[i].failed));
            chk($sformatf("row%0d count", i),  32'(gcnt_s[0]),   32'(tbl[i].cnt));
        end

        // Depth-1 history: first stored entry fills it; bad feedback fails immediately.
        drive(1, 1'b1, 1'b0, 4'd0, 4'd0);
        step();
        drive(1, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        chk("d1 gv", 32'(gv_s[1]), 32'd1);
        drive(1, 1'b0, 1'b1, 4'd0, 4'd0);
        step();
        drive(1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("d1 full failed", 32'(failed_s[1]), 32'd1);
        chk("d1 full busy",   32'(busy_s[1]),   32'd0);
        drive(1, 1'b1, 1'b0, 4'd0, 4'd0);
        step();
        drive(1, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        chk("d1 restart failed", 32'(failed_s[1]), 32'd0);
        drive(1, 1'b0, 1'b1, 4'd2, 4'd3);
        step();
        drive(1, 1'b0, 1'b0, 4'd0, 4'd0);
        chk("d1 bad failed", 32'(failed_s[1]), 32'd1);
        chk("d1 bad count",  32'(gcnt_s[1]),   32'd1);

        fork
            begin
                drive(0, 1'b1, 1'b0, 4'd0, 4'd0);
                step();
                drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
                step();
                chk("imp gv", 32'(gv_s[0]), 32'd1);
                drive(0, 1'b0, 1'b1, 4'd0, 4'd4);
                step();
                drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
                n    = 1;
                seen = 1'b0;
                while (!failed_s[0] && n < 70000) begin
                    if (gv_s[0]) seen = 1'b1;
                    step();
                    n++;
                end
                chk("imp fail latency", 32'(n), 32'd65536);
                chk("imp gv seen", 32'(seen), 32'd0);
                chk("imp busy", 32'(busy_s[0]), 32'd0);
            end
            begin
                play(2, 16'hA2C1, "A2C1");
            end
            begin
                play(3, 16'h3DE7, "3DE7");
            end
        join

        // Asynchronous reset in the middle of a long search.
        drive(0, 1'b1, 1'b0, 4'd0, 4'd0);
        step();
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        drive(0, 1'b0, 1'b1, 4'd3, 4'd0);
        step();
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        chk("rst pre guess", 32'(guess_s[0]), 32'h0001);
        drive(0, 1'b0, 1'b1, 4'd0, 4'd0);
        step();
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) step();
        chk("rst pre busy", 32'(busy_s[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
